// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator with a shared period counter. Each channel runs as counter PWM or as a
// 1st-order sigma-delta modulator. Duty values are double-buffered and committed at a period boundary.
module pwm_multi_ch #(
    parameter int CHANNELS = 8,
    parameter int DC_WIDTH = 8,
    parameter int CH_BITS  = 3
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                STB_CLK,
    input  logic                MODE,
    input  logic                DC_WR,
    input  logic [CH_BITS-1:0]  DC_CH,
    input  logic [DC_WIDTH-1:0] DC_DATA,
    input  logic                UPDATE,
    output logic                BUSY,
    output logic                UPDATE_DONE,
    output logic                PERIOD_START,
    output logic [CHANNELS-1:0] Q
);

    localparam logic [DC_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CH_BITS:0]    CH_LIMIT = CHANNELS[CH_BITS:0];

    logic [DC_WIDTH-1:0] cnt;
    logic [DC_WIDTH-1:0] shadow [CHANNELS];
    logic [DC_WIDTH-1:0] active [CHANNELS];
    logic [DC_WIDTH:0]   acc    [CHANNELS];
    logic                mode_shadow;
    logic                mode_act;
    logic                pending;

    logic                boundary;
    logic                commit;
    logic                mode_change;
    logic                wr_valid;
    logic [CHANNELS-1:0] q_nxt;

    assign boundary    = STB_CLK && (cnt == CNT_MAX);
    assign commit      = boundary && (pending || UPDATE);
    assign mode_change = commit && (mode_shadow != mode_act);
    assign wr_valid    = DC_WR && ({1'b0, DC_CH} < CH_LIMIT);
    assign BUSY        = pending;

    always_comb begin
        q_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            q_nxt[i] = mode_act ? acc[i][DC_WIDTH] : (cnt < active[i]);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt          <= '0;
            mode_shadow  <= 1'b0;
            mode_act     <= 1'b0;
            pending      <= 1'b0;
            UPDATE_DONE  <= 1'b0;
            PERIOD_START <= 1'b0;
            Q            <= '0;
        end else begin
            if (STB_CLK) begin
                cnt <= cnt + 1'b1;
            end
            mode_shadow  <= MODE;
            PERIOD_START <= boundary;
            UPDATE_DONE  <= commit;
            Q            <= q_nxt;
            if (commit) begin
                mode_act <= mode_shadow;
                pending  <= 1'b0;
            end else if (UPDATE) begin
                pending  <= 1'b1;
            end
        end
    end

    // Commit reads the pre-write shadow because both sample the same registered value.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
                acc[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_valid && (DC_CH == CH_BITS'(i))) begin
                    shadow[i] <= DC_DATA;
                end
                if (commit) begin
                    active[i] <= shadow[i];
                end
                if (mode_change) begin
                    acc[i] <= '0;
                end else if (STB_CLK) begin
                    acc[i] <= {1'b0, acc[i][DC_WIDTH-1:0]} + {1'b0, active[i]};
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: duty commit timing, channel decode, both modes, strobe division
// and asynchronous reset while a commit is pending.
module tb_pwm_multi_ch;

    localparam int NCH = 8;
    localparam int W   = 8;
    localparam int CB  = 4;

    logic           CLK;
    logic           RESET_N;
    logic           STB_CLK = 1'b1;
    logic           MODE;
    logic           DC_WR;
    logic [CB-1:0]  DC_CH;
    logic [W-1:0]   DC_DATA;
    logic           UPDATE;
    logic           BUSY;
    logic           UPDATE_DONE;
    logic           PERIOD_START;
    logic [NCH-1:0] Q;

    int        n_checks = 0;
    int        n_err    = 0;
    int        hi     [NCH];
    int        exp_hi [NCH];
    logic [NCH-1:0] qs [4];
    logic      stb_div = 1'b0;
    logic [1:0] ph = '0;

    pwm_multi_ch #(.CHANNELS(NCH), .DC_WIDTH(W), .CH_BITS(CB)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .STB_CLK      (STB_CLK),
        .MODE         (MODE),
        .DC_WR        (DC_WR),
        .DC_CH        (DC_CH),
        .DC_DATA      (DC_DATA),
        .UPDATE       (UPDATE),
        .BUSY         (BUSY),
        .UPDATE_DONE  (UPDATE_DONE),
        .PERIOD_START (PERIOD_START),
        .Q            (Q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (stb_div) begin
            ph      = ph + 2'd1;
            STB_CLK = (ph == 2'd0);
        end else begin
            STB_CLK = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_dc(input int ch, input int val);
        DC_WR   = 1'b1;
        DC_CH   = CB'(ch);
        DC_DATA = W'(val);
        @(negedge CLK);
        DC_WR   = 1'b0;
    endtask

    task automatic pulse_update();
        UPDATE = 1'b1;
        @(negedge CLK);
        UPDATE = 1'b0;
    endtask

    task automatic wait_ps(input int budget, input string tag, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!PERIOD_START && n < budget);
        check(tag, PERIOD_START, 1);
    endtask

    task automatic measure();
        for (int i = 0; i < NCH; i++) hi[i] = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge CLK);
            if (k < 4) qs[k] = Q;
            for (int i = 0; i < NCH; i++) hi[i] += int'(Q[i]);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("%s_ch%0d", tag, i), hi[i], exp_hi[i]);
        end
    endtask

    initial begin
        int n;
        int ud_seen;
        int q_seen;
        RESET_N = 1'b0;
        MODE    = 1'b0;
        DC_WR   = 1'b0;
        DC_CH   = '0;
        DC_DATA = '0;
        UPDATE  = 1'b0;
        for (int i = 0; i < NCH; i++) exp_hi[i] = 0;
        repeat (3) @(negedge CLK);
        check("rst_q", Q, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", UPDATE_DONE, 0);
        check("rst_ps", PERIOD_START, 0);
        RESET_N = 1'b1;

        // basic commit of one channel
        write_dc(0, 64);
        pulse_update();
        check("t1_busy", BUSY, 1);
        check("t1_done_early", UPDATE_DONE, 0);
        wait_ps(300, "t1_ps", n);
        check("t1_done", UPDATE_DONE, 1);
        check("t1_busy_clr", BUSY, 0);
        exp_hi[0] = 64;
        measure();
        check_all("t1");

        // shadow write without commit has no effect; commit lands on period start
        repeat (50) @(negedge CLK);
        write_dc(3, 200);
        wait_ps(300, "t2_ps_a", n);
        measure();
        check_all("t2_hold");
        repeat (20) @(negedge CLK);
        pulse_update();
        wait_ps(300, "t2_ps_b", n);
        check("t2_q3_before", Q[3], 0);
        @(negedge CLK);
        check("t2_q3_start", Q[3], 1);
        check("t2_done_width", UPDATE_DONE, 0);
        exp_hi[3] = 200;
        measure();
        check_all("t2");

        // out-of-range channel is ignored
        repeat (20) @(negedge CLK);
        write_dc(9, 77);
        write_dc(4, 30);
        pulse_update();
        wait_ps(300, "t3_ps_a", n);
        exp_hi[4] = 30;
        measure();
        check_all("t3_decode");

        // write and UPDATE in the boundary cycle: commit takes the old shadow
        repeat (255) @(negedge CLK);
        DC_WR   = 1'b1;
        DC_CH   = CB'(5);
        DC_DATA = W'(100);
        UPDATE  = 1'b1;
        @(negedge CLK);
        DC_WR   = 1'b0;
        UPDATE  = 1'b0;
        check("t3_ps_b", PERIOD_START, 1);
        check("t3_done_same", UPDATE_DONE, 1);
        measure();
        check_all("t3_old");
        pulse_update();
        wait_ps(300, "t3_ps_c", n);
        exp_hi[5] = 100;
        measure();
        check_all("t3_new");

        // sigma-delta mode, including the 0 / 255 extremes
        repeat (20) @(negedge CLK);
        MODE = 1'b1;
        write_dc(1, 128);
        write_dc(2, 1);
        write_dc(7, 255);
        pulse_update();
        wait_ps(300, "t4_ps_a", n);
        check("t4_done", UPDATE_DONE, 1);
        wait_ps(300, "t4_ps_b", n);
        exp_hi[1] = 128;
        exp_hi[2] = 1;
        exp_hi[7] = 255;
        measure();
        check_all("t4_sd");
        check("t4_toggle_a", qs[0][1] ^ qs[1][1], 1);
        check("t4_toggle_b", qs[1][1] ^ qs[2][1], 1);

        // back to counter mode with the same duties
        MODE = 1'b0;
        repeat (5) @(negedge CLK);
        pulse_update();
        wait_ps(300, "t6_ps_a", n);
        measure();
        check_all("t6_cnt");

        // strobe 1-in-4, then reset while a commit is pending
        stb_div = 1'b1;
        wait_ps(1100, "t5_sync", n);
        wait_ps(1100, "t5_ps", n);
        check("t5_period", n, 1024);
        repeat (100) @(negedge CLK);
        pulse_update();
        check("t5_busy", BUSY, 1);
        check("t5_q7_pre", Q[7], 1);
        RESET_N = 1'b0;
        #1;
        check("t5_rst_q", Q, 0);
        check("t5_rst_busy", BUSY, 0);
        check("t5_rst_ps", PERIOD_START, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        ud_seen = 0;
        q_seen  = 0;
        for (int k = 0; k < 2100; k++) begin
            @(negedge CLK);
            if (UPDATE_DONE) ud_seen++;
            if (Q != '0) q_seen++;
        end
        check("t5_no_done", ud_seen, 0);
        check("t5_q_idle", q_seen, 0);
        check("t5_busy_after", BUSY, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
